// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD message sequencer
package lcd_pkg;

  localparam int         MSG_LEN_DEF = 16;
  localparam int         TXT_LEN     = 7;
  localparam logic [7:0] SPACE       = 8'h20;

  typedef logic [1:0] class_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_BUSY,
    WAIT_READY,
    DONE
  } state_e;

  // Stored text, left-aligned; characters beyond TXT_LEN read as SPACE.
  localparam logic [0:TXT_LEN-1][7:0] TXT_SILENCE = "SILENCE";
  localparam logic [0:TXT_LEN-1][7:0] TXT_UNKNOWN = "UNKNOWN";
  localparam logic [0:TXT_LEN-1][7:0] TXT_YES     = "YES    ";
  localparam logic [0:TXT_LEN-1][7:0] TXT_NO      = "NO     ";

endpackage

// File: rtl/lcd_msg_rom.sv
// rtl/lcd_msg_rom.sv - per-class message table with a registered character output
module lcd_msg_rom import lcd_pkg::*; #(
  parameter  int MSG_LEN     = MSG_LEN_DEF,
  parameter  int NUM_CLASSES = 4,
  localparam int IW          = $clog2(MSG_LEN)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          rd_en_i,
  input  class_t        class_i,
  input  logic [IW-1:0] idx_i,
  output logic [7:0]    char_o
);

  logic [0:TXT_LEN-1][7:0] txt;
  logic [7:0]              char_d;
  logic [7:0]              char_q;

  always_comb begin
    txt    = TXT_UNKNOWN;
    char_d = SPACE;
    if (int'(class_i) < NUM_CLASSES) begin
      unique case (class_i)
        2'd0:    txt = TXT_SILENCE;
        2'd2:    txt = TXT_YES;
        2'd3:    txt = TXT_NO;
        default: txt = TXT_UNKNOWN;
      endcase
    end
    if (int'(idx_i) < TXT_LEN) begin
      char_d = txt[idx_i[2:0]];
    end
  end

  // Only reloaded in LOAD, so the character stays put through SEND and the wait states.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      char_q <= SPACE;
    end else if (rd_en_i) begin
      char_q <= char_d;
    end
  end

  assign char_o = char_q;

endmodule

// File: rtl/lcd_msg_sequencer.sv
// rtl/lcd_msg_sequencer.sv - streams a class message to an LCD driver one character per handshake
module lcd_msg_sequencer import lcd_pkg::*; #(
  parameter int MSG_LEN     = MSG_LEN_DEF,
  parameter int NUM_CLASSES = 4
) (
  input  logic       clk,
  input  logic       rstb,
  input  class_t     class_id,
  input  logic       class_valid,
  input  logic       char_ready,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       seq_busy,
  output logic       msg_done
);

  localparam int            IW       = $clog2(MSG_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_LEN - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  class_t        cur_q, cur_d;
  class_t        last_q, last_d;
  class_t        pend_q, pend_d;
  logic          last_vld_q, last_vld_d;
  logic          pend_vld_q, pend_vld_d;
  logic          char_valid_q, seq_busy_q, msg_done_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cur_d      = cur_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    unique case (state_q)
      IDLE: begin
        if (class_valid && !(last_vld_q && class_id == last_q)) begin
          state_d = LOAD;
          cur_d   = class_id;
          idx_d   = '0;
        end
      end
      LOAD:      state_d = SEND;
      SEND:      if (char_ready) state_d = WAIT_BUSY;
      WAIT_BUSY: if (!char_ready) state_d = WAIT_READY;
      WAIT_READY: begin
        if (char_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        last_d     = cur_q;
        last_vld_d = 1'b1;
        pend_vld_d = 1'b0;
        idx_d      = '0;
        // A strobe landing in DONE is newer than anything pending, so it wins.
        if (class_valid) begin
          state_d = LOAD;
          cur_d   = class_id;
        end else if (pend_vld_q) begin
          state_d = LOAD;
          cur_d   = pend_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (class_valid && state_q != IDLE && state_q != DONE) begin
      pend_d     = class_id;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cur_q        <= '0;
      last_q       <= '0;
      last_vld_q   <= 1'b0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      char_valid_q <= 1'b0;
      seq_busy_q   <= 1'b0;
      msg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      last_vld_q   <= last_vld_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      char_valid_q <= (state_d == SEND);
      seq_busy_q   <= (state_d != IDLE);
      msg_done_q   <= (state_d == DONE);
    end
  end

  lcd_msg_rom #(
    .MSG_LEN    (MSG_LEN),
    .NUM_CLASSES(NUM_CLASSES)
  ) u_rom (
    .clk    (clk),
    .rstb   (rstb),
    .rd_en_i(state_q == LOAD),
    .class_i(cur_q),
    .idx_i  (idx_q),
    .char_o (char_out)
  );

  assign char_valid = char_valid_q;
  assign seq_busy   = seq_busy_q;
  assign msg_done   = msg_done_q;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// tb/tb_lcd_msg_sequencer.sv - randomized bench with a message-level reference model
module tb_lcd_msg_sequencer;

  localparam int MSG_LEN        = 16;
  localparam int NUM_CLASSES    = 4;
  localparam int WAIT_PARAMETER = 20;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [1:0] class_id = 2'd0;
  logic       class_valid = 1'b0;
  logic       char_ready = 1'b1;
  logic [7:0] char_out;
  logic       char_valid, seq_busy, msg_done;

  int total = 0;
  int bad = 0;

  lcd_msg_sequencer #(.MSG_LEN(MSG_LEN), .NUM_CLASSES(NUM_CLASSES)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .class_id   (class_id),
    .class_valid(class_valid),
    .char_ready (char_ready),
    .char_out   (char_out),
    .char_valid (char_valid),
    .seq_busy   (seq_busy),
    .msg_done   (msg_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] msg_char(input int cls, input int i);
    string s;
    if (cls >= NUM_CLASSES) s = "UNKNOWN";
    else case (cls)
      0:       s = "SILENCE";
      2:       s = "YES";
      3:       s = "NO";
      default: s = "UNKNOWN";
    endcase
    return (i < s.len()) ? s[i] : 8'h20;
  endfunction

  function automatic string padded(input string s);
    string r;
    r = s;
    while (r.len() < MSG_LEN) r = {r, " "};
    return r;
  endfunction

  // Reference model: one message in flight, a one-deep last-wins pending slot, a repeat filter in idle.
  typedef enum int {M_IDLE, M_FETCH, M_SHOW, M_LOW, M_HIGH, M_END} mph_e;
  mph_e mph = M_IDLE;
  mph_e m_old;
  int   m_cls = 0, m_i = 0, m_last = 0, m_pend = 0;
  bit   m_last_ok = 0, m_pend_ok = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mph = M_IDLE; m_i = 0; m_pend_ok = 0; m_last_ok = 0;
    end else begin
      m_old = mph;
      case (mph)
        M_IDLE: if (class_valid && !(m_last_ok && int'(class_id) == m_last)) begin
          mph = M_FETCH; m_cls = int'(class_id); m_i = 0;
        end
        M_FETCH: mph = M_SHOW;
        M_SHOW:  if (char_ready) mph = M_LOW;
        M_LOW:   if (!char_ready) mph = M_HIGH;
        M_HIGH:  if (char_ready) begin
          if (m_i == MSG_LEN - 1) mph = M_END;
          else begin m_i++; mph = M_FETCH; end
        end
        M_END: begin
          m_last = m_cls; m_last_ok = 1;
          if (class_valid) begin
            m_cls = int'(class_id); m_i = 0; m_pend_ok = 0; mph = M_FETCH;
          end else if (m_pend_ok) begin
            m_cls = m_pend; m_i = 0; m_pend_ok = 0; mph = M_FETCH;
          end else mph = M_IDLE;
        end
        default: mph = M_IDLE;
      endcase
      if (class_valid && m_old != M_IDLE && m_old != M_END) begin
        m_pend = int'(class_id); m_pend_ok = 1;
      end
    end
  end

  logic [7:0] got[$];
  int         hs_cyc[$];
  int         done_cnt = 0;
  int         cv_cnt = 0;

  always @(negedge clk) begin
    if (rstb) begin
      check("char_valid", 32'(char_valid), 32'(mph == M_SHOW));
      check("seq_busy", 32'(seq_busy), 32'(mph != M_IDLE));
      check("msg_done", 32'(msg_done), 32'(mph == M_END));
      if (mph == M_SHOW) check("char_out", 32'(char_out), 32'(msg_char(m_cls, m_i)));
      if (char_valid && char_ready) begin
        got.push_back(char_out);
        hs_cyc.push_back(cyc);
      end
      if (msg_done) done_cnt++;
      if (char_valid) cv_cnt++;
    end
  end

  // LCD driver: ready drops drv_hi cycles after a handshake and stays low for a while.
  int drv_hi = 2;
  int drv_lo = 0;
  int lo_now;
  initial begin
    forever begin
      @(negedge clk);
      if (rstb && char_valid && char_ready) begin
        lo_now = (drv_lo == 0) ? int'($urandom_range(WAIT_PARAMETER, 1)) : drv_lo;
        @(posedge clk);
        repeat (drv_hi) @(posedge clk);
        #1 char_ready = 1'b0;
        repeat (lo_now) @(posedge clk);
        #1 char_ready = 1'b1;
      end
    end
  end

  task automatic strobe(input int c);
    @(posedge clk); #1 class_valid = 1'b1; class_id = 2'(c);
    @(posedge clk); #1 class_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (seq_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle"}, 32'(seq_busy), 32'd0);
  endtask

  task automatic wait_hs(input string name, input int cnt, input int budget);
    int n;
    n = 0;
    while (got.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " hs"}, 32'(got.size() >= cnt), 32'd1);
  endtask

  task automatic check_stream(input string name, input string want);
    int errs;
    errs = 0;
    check({name, " len"}, 32'(got.size()), 32'(want.len()));
    for (int i = 0; i < want.len() && i < got.size(); i++)
      if (got[i] !== want[i]) errs++;
    check({name, " text"}, 32'(errs), 32'd0);
  endtask

  initial begin
    int base;
    int n;

    repeat (3) @(negedge clk);
    check("rst char_valid", 32'(char_valid), 32'd0);
    check("rst char_out", 32'(char_out), 32'h20);
    check("rst seq_busy", 32'(seq_busy), 32'd0);
    check("rst msg_done", 32'(msg_done), 32'd0);
    @(posedge clk); #1 rstb = 1'b1;

    // first message, two-cycle latency
    @(posedge clk); #1 class_valid = 1'b1; class_id = 2'd2;
    @(posedge clk); #1 class_valid = 1'b0;
    @(negedge clk);
    check("latency1 char_valid", 32'(char_valid), 32'd0);
    @(negedge clk);
    check("latency2 char_valid", 32'(char_valid), 32'd1);
    wait_idle("yes", 1500);
    check_stream("yes", padded("YES"));
    check("yes done", 32'(done_cnt), 32'd1);

    // repeat of the displayed class is ignored
    got.delete(); done_cnt = 0; base = cv_cnt;
    strobe(2);
    repeat (30) @(negedge clk);
    check("repeat no char_valid", 32'(cv_cnt - base), 32'd0);
    check("repeat seq_busy", 32'(seq_busy), 32'd0);

    // strobes during a message: last one wins, current message completes
    strobe(3);
    wait_hs("no", 4, 1500);
    strobe(3);
    strobe(0);
    wait_idle("no+silence", 3000);
    check_stream("no+silence", {padded("NO"), padded("SILENCE")});
    check("no+silence done", 32'(done_cnt), 32'd2);

    // ready held high ten cycles after each handshake, then a single low cycle
    got.delete(); hs_cyc.delete(); done_cnt = 0;
    drv_hi = 10; drv_lo = 1;
    strobe(1);
    wait_idle("slow", 1500);
    check_stream("slow", padded("UNKNOWN"));
    check("slow gap", 32'((hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : 0), 32'd14);
    drv_hi = 2; drv_lo = 0;

    // reset during the eighth character
    got.delete();
    strobe(3);
    wait_hs("abort", 7, 1500);
    n = 0;
    while (!char_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort reached char 8", 32'(char_valid), 32'd1);
    #2 rstb = 1'b0;
    #1;
    check("abort char_valid", 32'(char_valid), 32'd0);
    check("abort char_out", 32'(char_out), 32'h20);
    check("abort seq_busy", 32'(seq_busy), 32'd0);
    check("abort msg_done", 32'(msg_done), 32'd0);
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    base = cv_cnt;
    repeat (40) @(negedge clk);
    check("abort no resume", 32'(cv_cnt - base), 32'd0);
    check("abort seq_busy after", 32'(seq_busy), 32'd0);

    // strobe exactly in the DONE cycle
    got.delete(); done_cnt = 0;
    strobe(2);
    n = 0;
    while (!msg_done && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("done-cycle reached", 32'(msg_done), 32'd1);
    class_valid = 1'b1; class_id = 2'd0;
    @(posedge clk); #1 class_valid = 1'b0;
    wait_idle("done-cycle", 3000);
    check_stream("done-cycle", {padded("YES"), padded("SILENCE")});
    check("done-cycle done", 32'(done_cnt), 32'd2);

    // random strobes, checked cycle by cycle against the model
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(400, 0)) @(posedge clk);
      strobe(int'($urandom_range(3, 0)));
    end
    wait_idle("random", 4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
